// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment controller: active-low segment
// patterns (a..g = bit 0..6) and the hex-to-segment mapping.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
   localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
   localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
   localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
   localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
   localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
   localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
   localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
   localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
   localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
   localparam logic [6:0] SEG_HEX_A = 7'b0001000;
   localparam logic [6:0] SEG_HEX_B = 7'b0000011;
   localparam logic [6:0] SEG_HEX_C = 7'b1000110;
   localparam logic [6:0] SEG_HEX_D = 7'b0100001;
   localparam logic [6:0] SEG_HEX_E = 7'b0000110;
   localparam logic [6:0] SEG_HEX_F = 7'b0001110;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      logic [6:0] s;
      case (nibble)
         4'h0: s = SEG_HEX_0;
         4'h1: s = SEG_HEX_1;
         4'h2: s = SEG_HEX_2;
         4'h3: s = SEG_HEX_3;
         4'h4: s = SEG_HEX_4;
         4'h5: s = SEG_HEX_5;
         4'h6: s = SEG_HEX_6;
         4'h7: s = SEG_HEX_7;
         4'h8: s = SEG_HEX_8;
         4'h9: s = SEG_HEX_9;
         4'hA: s = SEG_HEX_A;
         4'hB: s = SEG_HEX_B;
         4'hC: s = SEG_HEX_C;
         4'hD: s = SEG_HEX_D;
         4'hE: s = SEG_HEX_E;
         default: s = SEG_HEX_F;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// Bus between a datapath (master) and the seven-segment controller (slave).
// Handshake: load is a one-cycle request; the controller captures
// digit_data/blank/dp_in/bright on any cycle load=1 (there is no ready, a new
// load simply overwrites the pending one). busy=1 means a captured value is
// waiting for the next frame boundary to become visible.
interface seven_seg_display_ctrl_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BRIGHT_W   = 3
);
   logic                    load;
   logic [4*NUM_DIGITS-1:0] digit_data;
   logic [NUM_DIGITS-1:0]   blank;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [BRIGHT_W-1:0]     bright;
   logic                    busy;
   logic                    frame_done;
   logic [NUM_DIGITS-1:0]   an;
   logic [6:0]              seg;
   logic                    dp;

   modport master (
      output load, digit_data, blank, dp_in, bright,
      input  busy, frame_done, an, seg, dp
   );

   modport slave (
      input  load, digit_data, blank, dp_in, bright,
      output busy, frame_done, an, seg, dp
   );
endinterface

// File: rtl/seven_seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment decoder.
module seven_seg_hex_lut
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Pure table lookup
   always_comb seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// Time-multiplexed N-digit seven-segment controller (common anode,
// active-low an/seg/dp). Prescaler sets the slot length, the scanner walks
// the digits, a shadow register set is transferred to the active set only at
// frame boundaries so a frame never mixes old and new values, and the top
// prescaler bits drive a PWM brightness gate.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seven_seg_display_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int DIVIDE_BY  = 17,
   parameter int BRIGHT_W   = 3
) (
   input  logic clock,
   input  logic reset,
   seven_seg_display_ctrl_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [DIVIDE_BY-1:0]    pre_cnt_q;
   logic [IDX_W-1:0]        digit_idx_q;

   logic [4*NUM_DIGITS-1:0] sh_data_q,   act_data_q;
   logic [NUM_DIGITS-1:0]   sh_blank_q,  act_blank_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q,     act_dp_q;
   logic [BRIGHT_W-1:0]     sh_bright_q, act_bright_q;
   logic                    busy_q,      busy_d;

   logic [NUM_DIGITS-1:0]   an_q,  an_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q,  dp_d;

   logic                    slot_tick;
   logic                    frame_end;
   logic [BRIGHT_W-1:0]     phase;
   logic                    pwm_on;
   logic [3:0]              sel_nib;
   logic                    sel_blank;
   logic                    sel_dp;
   logic                    sel_lz;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [6:0]              lut_seg;

   assign slot_tick = &pre_cnt_q;
   assign frame_end = slot_tick && (digit_idx_q == LAST_IDX);
   assign phase     = pre_cnt_q[DIVIDE_BY-1 -: BRIGHT_W];
   // All-ones brightness must be fully on, which phase < bright cannot reach.
   assign pwm_on    = (&act_bright_q) || (phase < act_bright_q);

   // Prescaler free-runs; scanner steps one digit per slot and wraps at the last digit
   always_ff @(posedge clock) begin
      if (!reset) begin
         pre_cnt_q   <= '0;
         digit_idx_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_q + 1'b1;
         if (slot_tick)
            digit_idx_q <= (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + 1'b1;
      end
   end

   // A fresh load keeps busy set even if it lands on a boundary; otherwise the boundary drains it
   always_comb begin
      busy_d = busy_q;
      if (bus.load)
         busy_d = 1'b1;
      else if (frame_end)
         busy_d = 1'b0;
   end

   // Shadow capture on load; shadow-to-active transfer at the frame boundary
   always_ff @(posedge clock) begin
      if (!reset) begin
         sh_data_q    <= '0;
         sh_blank_q   <= '0;
         sh_dp_q      <= '0;
         sh_bright_q  <= '0;
         act_data_q   <= '0;
         act_blank_q  <= '1;
         act_dp_q     <= '0;
         act_bright_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         if (frame_end && busy_q) begin
            act_data_q   <= sh_data_q;
            act_blank_q  <= sh_blank_q;
            act_dp_q     <= sh_dp_q;
            act_bright_q <= sh_bright_q;
         end
         if (bus.load) begin
            sh_data_q   <= bus.digit_data;
            sh_blank_q  <= bus.blank;
            sh_dp_q     <= bus.dp_in;
            sh_bright_q <= bus.bright;
         end
         busy_q <= busy_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // Digit i (i>0) is suppressed when it and every more significant digit are zero
   always_comb begin
      logic higher_zero;
      lz_mask     = '0;
      higher_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         higher_zero = higher_zero && (act_data_q[4*i +: 4] == 4'h0);
         lz_mask[i]  = higher_zero;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // Pick the active fields belonging to the digit currently being scanned
   always_comb begin
      sel_nib   = '0;
      sel_blank = 1'b1;
      sel_dp    = 1'b0;
      sel_lz    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx_q == IDX_W'(i)) begin
            sel_nib   = act_data_q[4*i +: 4];
            sel_blank = act_blank_q[i];
            sel_dp    = act_dp_q[i];
            sel_lz    = lz_mask[i];
         end
      end
   end

   seven_seg_hex_lut u_lut (
      .nibble_i (sel_nib),
      .seg_o    (lut_seg)
   );

   // Next output values; a suppressed leading zero keeps its anode only to show a lit dp
   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (pwm_on) begin
         seg_d = sel_lz ? SEG_BLANK : lut_seg;
         dp_d  = ~sel_dp;
         if (!sel_blank && (!sel_lz || sel_dp))
            an_d = ~(NUM_DIGITS'(1) << digit_idx_q);
      end
   end

   // Registered pin drivers
   always_ff @(posedge clock) begin
      if (!reset) begin
         an_q  <= '1;
         seg_q <= SEG_BLANK;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Bench for seven_seg_display_ctrl with 4 digits, 16-cycle slots, 2-bit
// brightness. A cycle-count based reference model predicts every output on
// every cycle; directed scenarios are followed by random traffic.
module tb_seven_seg_display_ctrl;

   localparam int ND    = 4;
   localparam int DIV   = 4;
   localparam int BW    = 2;
   localparam int SLOT  = 1 << DIV;
   localparam int FRAME = ND * SLOT;

   logic clock;
   logic reset;

   seven_seg_display_ctrl_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

   seven_seg_display_ctrl #(
      .NUM_DIGITS (ND),
      .DIVIDE_BY  (DIV),
      .BRIGHT_W   (BW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int          m_t;          // cycles since the last reset edge
   logic        m_busy;
   logic [15:0] m_sh_d,  m_act_d;
   logic [3:0]  m_sh_b,  m_act_b;
   logic [3:0]  m_sh_p,  m_act_p;
   logic [1:0]  m_sh_br, m_act_br;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   task automatic model_step(input logic rn, input logic ld, input logic [15:0] d,
                             input logic [3:0] bl, input logic [3:0] dpi, input logic [1:0] br);
      int    slot, ph;
      bit    on, sup, boundary;
      logic [3:0] nib;
      if (!rn) begin
         m_t = 0; m_busy = 0;
         m_sh_d = 0; m_sh_b = 0; m_sh_p = 0; m_sh_br = 0;
         m_act_d = 0; m_act_b = 4'hF; m_act_p = 0; m_act_br = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         return;
      end
      slot = (m_t / SLOT) % ND;
      ph   = (m_t % SLOT) / (SLOT / (1 << BW));
      on   = (m_act_br == 2'd3) || (ph < int'(m_act_br));
      nib  = 4'((m_act_d >> (4 * slot)) & 16'hF);
      sup  = 0;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot > 0) begin
         sup = 1;
         for (int j = slot; j < ND; j++)
            if (((m_act_d >> (4 * j)) & 16'hF) != 0) sup = 0;
      end
`endif
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (on) begin
         e_seg = sup ? 7'h7F : hex_tab[nib];
         e_dp  = !m_act_p[slot];
         if (!m_act_b[slot] && (!sup || m_act_p[slot]))
            e_an = 4'hF & ~(4'b0001 << slot);
      end
      boundary = (m_t % FRAME) == FRAME - 1;
      if (boundary && m_busy) begin
         m_act_d = m_sh_d; m_act_b = m_sh_b; m_act_p = m_sh_p; m_act_br = m_sh_br;
      end
      if (ld) begin
         m_sh_d = d; m_sh_b = bl; m_sh_p = dpi; m_sh_br = br; m_busy = 1;
      end else if (boundary) begin
         m_busy = 0;
      end
      m_t++;
   endtask

   // ---------------- driver ----------------
   task automatic tick(input logic rn, input logic ld, input logic [15:0] d,
                       input logic [3:0] bl, input logic [3:0] dpi, input logic [1:0] br);
      reset          = rn;
      bus.load       = ld;
      bus.digit_data = d;
      bus.blank      = bl;
      bus.dp_in      = dpi;
      bus.bright     = br;
      @(posedge clock);
      model_step(rn, ld, d, bl, dpi, br);
      @(negedge clock);
      check_eq("an", 32'(bus.an), 32'(e_an));
      check_eq("seg", 32'(bus.seg), 32'(e_seg));
      check_eq("dp", 32'(bus.dp), 32'(e_dp));
      check_eq("busy", 32'(bus.busy), 32'(m_busy));
      check_eq("frame_done", 32'(bus.frame_done), 32'((m_t % FRAME) == FRAME - 1));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 2'd0);
   endtask

   task automatic load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] dpi,
                       input logic [1:0] br);
      tick(1'b1, 1'b1, d, bl, dpi, br);
   endtask

   // Run until the next clock edge is a frame boundary (bounded)
   task automatic run_to_boundary();
      for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) idle(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0;
      bus.load = 1'b0; bus.digit_data = '0; bus.blank = '0; bus.dp_in = '0; bus.bright = '0;
      @(negedge clock);

      // reset held for 3 cycles, then a full dark frame with nothing loaded
      for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 2'd0);
      idle(FRAME + 6);

      // full-brightness value with one decimal point
      load(16'h12AF, 4'b0000, 4'b0100, 2'd3);
      idle(3 * FRAME);

      // quarter duty, then fully dark
      load(16'h8421, 4'b0000, 4'b1001, 2'd1);
      idle(2 * FRAME);
      load(16'h8421, 4'b0000, 4'b1111, 2'd0);
      idle(2 * FRAME);

      // two loads in one frame, then a load coincident with the boundary
      run_to_boundary();
      idle(5);
      load(16'h1111, 4'b0000, 4'b0000, 2'd3);
      idle(10);
      load(16'h2222, 4'b0000, 4'b0000, 2'd3);
      run_to_boundary();
      load(16'h3333, 4'b0010, 4'b0001, 2'd2);
      check_eq("busy_held_over_boundary", 32'(bus.busy), 32'd1);
      idle(3 * FRAME);

      // reset mid-slot with a pending load: the pending value must never show
      idle(7);
      load(16'hBEEF, 4'b0000, 4'b1111, 2'd3);
      idle(3);
      tick(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 2'd0);
      check_eq("busy_after_reset", 32'(bus.busy), 32'd0);
      check_eq("an_after_reset", 32'(bus.an), 32'hF);
      idle(2 * FRAME);

      // leading-zero patterns and blank masks
      load(16'h0050, 4'b0000, 4'b0000, 2'd3);
      idle(2 * FRAME);
      load(16'h0000, 4'b0000, 4'b1000, 2'd3);
      idle(2 * FRAME);
      load(16'h9C3D, 4'b0101, 4'b0011, 2'd3);
      idle(2 * FRAME);

      // random traffic, including occasional resets
      for (int k = 0; k < 3000; k++) begin
         logic rn, ld;
         rn = ($urandom_range(0, 599) != 0);
         ld = ($urandom_range(0, 39) == 0);
         tick(rn, ld, 16'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              4'($urandom), 2'($urandom_range(0, 3)));
      end
      idle(2 * FRAME);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
